// File: rtl/aes_key_schedule.sv
// AES-128 key schedule: expands one cipher key into NR+1 stored round keys, one round per clock,
// and serves them through a registered random-access read port.

// One round of AES-128 key expansion: Key_Out = round key (Round_Count+1) derived from Key.
module KeyGeneration (
    input  logic [3:0]   Round_Count,
    input  logic [127:0] Key,
    output logic [127:0] Key_Out
);
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // S-box computed as multiplicative inverse (x^254, 0 maps to 0) followed by the affine map.
    function automatic logic [7:0] sbox(input logic [7:0] v);
        logic [7:0] p;
        logic [7:0] r;
        p = v;
        r = 8'h01;
        for (int i = 1; i < 8; i++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
    endfunction

    logic [31:0] w0, w1, w2, w3;
    logic [31:0] rot, sub, temp;
    logic [7:0]  rcon;
    logic [31:0] w4, w5, w6, w7;

    always_comb begin
        rcon = 8'h00;
        case (Round_Count)
            4'd0: rcon = 8'h01;
            4'd1: rcon = 8'h02;
            4'd2: rcon = 8'h04;
            4'd3: rcon = 8'h08;
            4'd4: rcon = 8'h10;
            4'd5: rcon = 8'h20;
            4'd6: rcon = 8'h40;
            4'd7: rcon = 8'h80;
            4'd8: rcon = 8'h1b;
            4'd9: rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    end

    assign {w0, w1, w2, w3} = Key;
    assign rot  = {w3[23:0], w3[31:24]};
    assign sub  = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])};
    assign temp = sub ^ {rcon, 24'h000000};
    assign w4   = w0 ^ temp;
    assign w5   = w1 ^ w4;
    assign w6   = w2 ^ w5;
    assign w7   = w3 ^ w6;
    assign Key_Out = {w4, w5, w6, w7};
endmodule

// state  | meaning
// IDLE   | no key loaded since reset; ready for a key
// EXPAND | computing round keys 1..NR, one per clock
// DONE   | all round keys stored and valid; ready for a new key
module aes_key_schedule #(
    parameter int NR = 10
) (
    input  logic         Clk,
    input  logic         Reset_n,
    input  logic [127:0] Key_In,
    input  logic         Key_Valid,
    output logic         Key_Ready,
    output logic         Busy,
    output logic         Keys_Valid,
    input  logic [3:0]   Rd_Round,
    output logic [127:0] Rd_Key
);
    typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_t;

    state_t       state;
    logic [3:0]   round_cnt;
    logic [3:0]   next_cnt;
    logic [127:0] slot [0:NR];
    logic [127:0] gen_key;
    logic         accept;

    assign accept   = Key_Valid & Key_Ready;
    assign next_cnt = round_cnt + 4'd1;

    KeyGeneration u_keygen (
        .Round_Count (round_cnt),
        .Key         (slot[round_cnt]),
        .Key_Out     (gen_key)
    );

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state      <= IDLE;
            round_cnt  <= 4'd0;
            Busy       <= 1'b0;
            Keys_Valid <= 1'b0;
            Key_Ready  <= 1'b1;
            for (int i = 0; i <= NR; i++) slot[i] <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (accept) begin
                        slot[0]    <= Key_In;
                        round_cnt  <= 4'd0;
                        state      <= EXPAND;
                        Busy       <= 1'b1;
                        Keys_Valid <= 1'b0;
                        Key_Ready  <= 1'b0;
                    end
                end
                EXPAND: begin
                    slot[next_cnt] <= gen_key;
                    if (round_cnt == 4'(NR - 1)) begin
                        round_cnt  <= 4'd0;
                        state      <= DONE;
                        Busy       <= 1'b0;
                        Keys_Valid <= 1'b1;
                        Key_Ready  <= 1'b1;
                    end else begin
                        round_cnt <= next_cnt;
                    end
                end
                default: begin
                    state     <= IDLE;
                    round_cnt <= 4'd0;
                    Busy      <= 1'b0;
                    Key_Ready <= 1'b1;
                end
            endcase
        end
    end

    // Read sees the slot contents before any write on the same edge.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            Rd_Key <= '0;
        end else if (Rd_Round <= 4'(NR)) begin
            Rd_Key <= slot[Rd_Round];
        end else begin
            Rd_Key <= '0;
        end
    end
endmodule
